// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: bus addresses, UART_CON bit
// positions and the state encoding used by both serial engines.
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_INT_EN = 0;
  localparam int CON_RX_INT_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_READY  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_FRAME_ERR = 5;
  localparam int CON_OVERRUN   = 6;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: two-flop synchroniser, mid-bit sampling FSM and shift
// register. Emits one-cycle pulses for a good byte or a bad stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 10417
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic [7:0] o_data
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  logic [1:0]    r_sync;
  uart_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          w_rxS;
  logic          w_fall;

  assign w_rxS  = r_sync[1];
  assign w_fall = r_sync[1] & ~r_sync[0];
  assign o_data = r_shift;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_rx};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bitIdx     <= '0;
      r_shift      <= '0;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt    <= '0;
          r_bitIdx <= '0;
          if (w_fall) r_state <= START;
        end
        START: begin
          // Half-bit recheck rejects glitches shorter than half a bit period.
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_state <= w_rxS ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == LAST) begin
            r_cnt    <= '0;
            r_shift  <= {w_rxS, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 1'b1;
            if (r_bitIdx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (w_rxS) o_byte_valid <= 1'b1;
            else       o_frame_err  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_periph.sv
// UART bus responder for the MIPS data bus: TXD/RXD/UART_CON decode, status
// flags, 8N1 transmitter and level interrupt request.
module uart_periph
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 10417
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic w_selTxd, w_selRxd, w_selCon;
  logic w_txdWrite, w_conWrite, w_conRead;
  logic w_txFinish, w_txBusy;
  logic w_byteValid, w_frameErrPulse;
  logic [7:0] w_rxByte;
  logic [6:0] w_con;
  logic w_unused;

  uart_state_e   r_txState;
  logic [CW-1:0] r_txCnt;
  logic [2:0]    r_txBit;
  logic [7:0]    r_txLatch;
  logic          r_tx;
  logic          r_txIntEn, r_rxIntEn, r_txDone, r_rxReady, r_frameErr, r_overrun;
  logic [7:0]    r_rxData;

  assign w_selTxd   = (Address == UART_TXD_ADDR);
  assign w_selRxd   = (Address == UART_RXD_ADDR);
  assign w_selCon   = (Address == UART_CON_ADDR);
  assign w_txdWrite = MemWrite & w_selTxd;
  assign w_conWrite = MemWrite & w_selCon;
  assign w_conRead  = MemRead & w_selCon;
  assign w_txBusy   = (r_txState != IDLE);
  assign w_txFinish = (r_txState == STOP) && (r_txCnt == LAST);
  assign w_unused   = ^WriteData[31:8];

  assign tx  = r_tx;
  assign irq = (r_txDone & r_txIntEn) | (r_rxReady & r_rxIntEn);

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_rx        (rx),
    .o_byte_valid(w_byteValid),
    .o_frame_err (w_frameErrPulse),
    .o_data      (w_rxByte)
  );

  // tx is registered one state behind, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txState <= IDLE;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txLatch <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_txState)
        IDLE: begin
          r_tx    <= 1'b1;
          r_txCnt <= '0;
          r_txBit <= '0;
          if (w_txdWrite) begin
            r_txLatch <= WriteData[7:0];
            r_txState <= START;
          end
        end
        START: begin
          r_tx <= 1'b0;
          if (r_txCnt == LAST) begin
            r_txCnt   <= '0;
            r_txState <= DATA;
          end else begin
            r_txCnt <= r_txCnt + 1'b1;
          end
        end
        DATA: begin
          r_tx <= r_txLatch[r_txBit];
          if (r_txCnt == LAST) begin
            r_txCnt <= '0;
            r_txBit <= r_txBit + 1'b1;
            if (r_txBit == 3'd7) r_txState <= STOP;
          end else begin
            r_txCnt <= r_txCnt + 1'b1;
          end
        end
        STOP: begin
          r_tx <= 1'b1;
          if (r_txCnt == LAST) begin
            r_txCnt   <= '0;
            r_txState <= IDLE;
          end else begin
            r_txCnt <= r_txCnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky flags: a set event outranks the read-to-clear at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txIntEn  <= 1'b0;
      r_rxIntEn  <= 1'b0;
      r_txDone   <= 1'b0;
      r_rxReady  <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
      r_rxData   <= '0;
    end else begin
      if (w_conWrite) begin
        r_txIntEn <= WriteData[0];
        r_rxIntEn <= WriteData[1];
      end
      if (w_txFinish)      r_txDone <= 1'b1;
      else if (w_conRead)  r_txDone <= 1'b0;
      if (w_byteValid)     r_rxReady <= 1'b1;
      else if (w_conRead)  r_rxReady <= 1'b0;
      if (w_frameErrPulse) r_frameErr <= 1'b1;
      else if (w_conRead)  r_frameErr <= 1'b0;
      if (w_byteValid && r_rxReady) r_overrun <= 1'b1;
      else if (w_conRead)           r_overrun <= 1'b0;
      if (w_byteValid) r_rxData <= w_rxByte;
    end
  end

  always_comb begin
    w_con                = '0;
    w_con[CON_TX_INT_EN] = r_txIntEn;
    w_con[CON_RX_INT_EN] = r_rxIntEn;
    w_con[CON_TX_DONE]   = r_txDone;
    w_con[CON_RX_READY]  = r_rxReady;
    w_con[CON_TX_BUSY]   = w_txBusy;
    w_con[CON_FRAME_ERR] = r_frameErr;
    w_con[CON_OVERRUN]   = r_overrun;
    ReadData = '0;
    if (w_selTxd)      ReadData = {24'h0, r_txLatch};
    else if (w_selRxd) ReadData = {24'h0, r_rxData};
    else if (w_selCon) ReadData = {25'h0, w_con};
  end

endmodule
